forwarding_unit: RTL and testbench

Pipeline hazard controller that drives the 2-bit select inputs of the ALU-operand 3-to-1 forwarding muxes in the five-stage MIPS datapath and raises the load-use stall. It receives decode-stage register tags, carries them through its own ID/EX, EX/MEM and MEM/WB tag registers in lockstep with the datapath pipeline registers, and compares the tags. It also keeps saturating stall and forward event counters for the performance test programs.

---
 rtl/forwarding_unit.sv | 156 +++++++++++++++
 tb/tb_forwarding_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
//
// Hazard controller for the five-stage MIPS datapath. Carries decode-stage
// register tags through private ID/EX, EX/MEM and MEM/WB tag registers that
// advance in lockstep with the datapath pipeline registers, then compares them
// to drive the ALU-operand forwarding mux selects and the load-use stall.
// Two saturating event counters report stall cycles and forwarding cycles.
//
// Ports:
//   Clk          pipeline clock, all state updates on the rising edge
//   Rst          synchronous active-high reset
//   ID_Rs/ID_Rt  source register fields of the instruction in ID
//   ID_UsesRs/Rt instruction in ID reads rs/rt as an ALU operand
//   ID_WriteReg  destination register of the instruction in ID
//   ID_RegWrite  instruction in ID writes the register file
//   ID_MemRead   instruction in ID is a load
//   Flush        squash the instruction in ID
//   Stall        load-use hazard: hold PC and IF/ID, bubble ID/EX
//   ForwardA/B   operand mux select: 0 = regfile, 1 = MEM/WB, 2 = EX/MEM
//   StallCount   saturating count of stall cycles
//   FwdCount     saturating count of cycles with any nonzero select
// -----------------------------------------------------------------------------
module forwarding_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_WriteReg,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             Flush,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FwdCount
);

    localparam logic [1:0] SelRegFile = 2'd0;
    localparam logic [1:0] SelMemWb   = 2'd1;
    localparam logic [1:0] SelExMem   = 2'd2;

    // EX stage tags
    logic [4:0] ex_rs_q;
    logic [4:0] ex_rt_q;
    logic       ex_uses_rs_q;
    logic       ex_uses_rt_q;
    logic [4:0] ex_write_reg_q;
    logic       ex_reg_write_q;
    logic       ex_mem_read_q;

    // MEM stage tags
    logic [4:0] mem_write_reg_q;
    logic       mem_reg_write_q;
    logic       mem_mem_read_q;

    // WB stage tags
    logic [4:0] wb_write_reg_q;
    logic       wb_reg_write_q;

    logic       stall_rs;
    logic       stall_rt;
    logic       mem_fwd_ok;
    logic       wb_fwd_ok;
    logic       fwd_event;

    // Load-use detection against the load currently in EX.
    always_comb begin
        stall_rs = ID_UsesRs && (ID_Rs == ex_write_reg_q);
        stall_rt = ID_UsesRt && (ID_Rt == ex_write_reg_q);
        Stall    = !Flush && ex_mem_read_q && ex_reg_write_q &&
                   (ex_write_reg_q != 5'd0) && (stall_rs || stall_rt);
    end

    // Selects depend only on tag registers so they never glitch with ID inputs.
    // A load in MEM has no result on the EX/MEM bus yet; the stall already keeps
    // a bubble between it and any consumer, the qualifier just makes that explicit.
    always_comb begin
        mem_fwd_ok = mem_reg_write_q && !mem_mem_read_q && (mem_write_reg_q != 5'd0);
        wb_fwd_ok  = wb_reg_write_q && (wb_write_reg_q != 5'd0);

        ForwardA = SelRegFile;
        if (mem_fwd_ok && ex_uses_rs_q && (mem_write_reg_q == ex_rs_q)) begin
            ForwardA = SelExMem;
        end else if (wb_fwd_ok && ex_uses_rs_q && (wb_write_reg_q == ex_rs_q)) begin
            ForwardA = SelMemWb;
        end

        ForwardB = SelRegFile;
        if (mem_fwd_ok && ex_uses_rt_q && (mem_write_reg_q == ex_rt_q)) begin
            ForwardB = SelExMem;
        end else if (wb_fwd_ok && ex_uses_rt_q && (wb_write_reg_q == ex_rt_q)) begin
            ForwardB = SelMemWb;
        end

        fwd_event = (ForwardA != SelRegFile) || (ForwardB != SelRegFile);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ex_rs_q         <= 5'd0;
            ex_rt_q         <= 5'd0;
            ex_uses_rs_q    <= 1'b0;
            ex_uses_rt_q    <= 1'b0;
            ex_write_reg_q  <= 5'd0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_write_reg_q <= 5'd0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            wb_write_reg_q  <= 5'd0;
            wb_reg_write_q  <= 1'b0;
            StallCount      <= '0;
            FwdCount        <= '0;
        end else begin
            wb_write_reg_q  <= mem_write_reg_q;
            wb_reg_write_q  <= mem_reg_write_q;

            mem_write_reg_q <= ex_write_reg_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_mem_read_q  <= ex_mem_read_q;

            if (Stall || Flush) begin
                ex_rs_q        <= 5'd0;
                ex_rt_q        <= 5'd0;
                ex_uses_rs_q   <= 1'b0;
                ex_uses_rt_q   <= 1'b0;
                ex_write_reg_q <= 5'd0;
                ex_reg_write_q <= 1'b0;
                ex_mem_read_q  <= 1'b0;
            end else begin
                ex_rs_q        <= ID_Rs;
                ex_rt_q        <= ID_Rt;
                ex_uses_rs_q   <= ID_UsesRs;
                ex_uses_rt_q   <= ID_UsesRt;
                ex_write_reg_q <= ID_WriteReg;
                ex_reg_write_q <= ID_RegWrite;
                ex_mem_read_q  <= ID_MemRead;
            end

            // Saturate at all-ones instead of wrapping.
            if (Stall && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (fwd_event && (FwdCount != {CNT_W{1'b1}})) begin
                FwdCount <= FwdCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_unit
//
// Directed bench for forwarding_unit. Two instances share all inputs: one with
// the default 16-bit counters and one with 4-bit counters for saturation.
// Inputs change 1 time unit after each rising edge; combinational outputs are
// sampled 1 time unit later, counters are sampled after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_forwarding_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_write_reg;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;

    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;

    logic        stall4;
    logic [1:0]  fwd_a4;
    logic [1:0]  fwd_b4;
    logic [3:0]  stall_cnt4;
    logic [3:0]  fwd_cnt4;

    int total = 0;
    int bad   = 0;

    forwarding_unit #(.CNT_W(16)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .ID_Rs      (id_rs),
        .ID_Rt      (id_rt),
        .ID_UsesRs  (id_uses_rs),
        .ID_UsesRt  (id_uses_rt),
        .ID_WriteReg(id_write_reg),
        .ID_RegWrite(id_reg_write),
        .ID_MemRead (id_mem_read),
        .Flush      (flush),
        .Stall      (stall),
        .ForwardA   (fwd_a),
        .ForwardB   (fwd_b),
        .StallCount (stall_cnt),
        .FwdCount   (fwd_cnt)
    );

    forwarding_unit #(.CNT_W(4)) dut4 (
        .Clk        (clk),
        .Rst        (rst),
        .ID_Rs      (id_rs),
        .ID_Rt      (id_rt),
        .ID_UsesRs  (id_uses_rs),
        .ID_UsesRt  (id_uses_rt),
        .ID_WriteReg(id_write_reg),
        .ID_RegWrite(id_reg_write),
        .ID_MemRead (id_mem_read),
        .Flush      (flush),
        .Stall      (stall4),
        .ForwardA   (fwd_a4),
        .ForwardB   (fwd_b4),
        .StallCount (stall_cnt4),
        .FwdCount   (fwd_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an instruction in ID, then let combinational outputs settle.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] wr, input logic rw,
                         input logic mr);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_write_reg = wr;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Common instruction shapes.
    task automatic lw8();   // lw $8, 0($29)
        drive(5'd29, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    endtask

    task automatic add9_8_1();  // add $9,$8,$1
        drive(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    endtask

    task automatic add8_9_10();  // add $8,$9,$10
        drive(5'd9, 5'd10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;

        // ---- reset after arbitrary traffic ----
        drive(5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
        step();
        drive(5'd7, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
        check("rst_stall_cnt4", 32'(stall_cnt4), 32'd0);
        step();

        // ---- EX/MEM forward: add $8,$9,$10 ; sub $11,$8,$12 ----
        add8_9_10();
        step();
        drive(5'd8, 5'd12, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        check("exmem_prod_in_ex_fa", 32'(fwd_a), 32'd0);
        step();
        idle();
        check("exmem_fa", 32'(fwd_a), 32'd2);
        check("exmem_fb", 32'(fwd_b), 32'd0);
        step();
        check("exmem_fwd_cnt", 32'(fwd_cnt), 32'd1);
        check("exmem_bubble_fa", 32'(fwd_a), 32'd0);
        step();
        step();

        // ---- MEM/WB forward: add $8 ; nop ; or $13,$12,$8 ----
        add8_9_10();
        step();
        idle();
        step();
        drive(5'd12, 5'd8, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
        step();
        idle();
        check("memwb_fa", 32'(fwd_a), 32'd0);
        check("memwb_fb", 32'(fwd_b), 32'd1);
        step();
        check("memwb_fwd_cnt", 32'(fwd_cnt), 32'd2);
        step();
        step();

        // ---- priority: add $8 ; add $8 ; and $14,$8,$8 ----
        add8_9_10();
        step();
        add8_9_10();
        step();
        drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
        step();
        idle();
        check("prio_fa", 32'(fwd_a), 32'd2);
        check("prio_fb", 32'(fwd_b), 32'd2);
        step();
        check("prio_fwd_cnt", 32'(fwd_cnt), 32'd3);
        step();
        step();

        // ---- n+3 consumer reads the register file: add $8 ; nop ; nop ; use $8 ----
        add8_9_10();
        step();
        idle();
        step();
        step();
        drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
        step();
        idle();
        check("n3_fa", 32'(fwd_a), 32'd0);
        check("n3_fb", 32'(fwd_b), 32'd0);
        step();
        check("n3_fwd_cnt", 32'(fwd_cnt), 32'd3);
        step();
        step();

        // ---- load-use: lw $8 ; add $9,$8,$1 ----
        lw8();
        check("lu_no_stall_lw_in_id", 32'(stall), 32'd0);
        step();
        add9_8_1();
        check("lu_stall", 32'(stall), 32'd1);
        step();
        check("lu_stall_released", 32'(stall), 32'd0);
        check("lu_bubble_fa", 32'(fwd_a), 32'd0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step();
        idle();
        check("lu_fa", 32'(fwd_a), 32'd1);
        check("lu_fb", 32'(fwd_b), 32'd0);
        step();
        check("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);
        check("lu_fwd_cnt", 32'(fwd_cnt), 32'd4);
        step();
        step();

        // ---- $0 never forwards or stalls ----
        drive(5'd9, 5'd10, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);  // add $0,$9,$10
        step();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);  // use $0
        step();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);  // use $0 again
        check("r0_exmem_fa", 32'(fwd_a), 32'd0);
        check("r0_exmem_fb", 32'(fwd_b), 32'd0);
        step();
        drive(5'd29, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0
        check("r0_memwb_fa", 32'(fwd_a), 32'd0);
        check("r0_memwb_fb", 32'(fwd_b), 32'd0);
        step();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
        check("r0_no_stall", 32'(stall), 32'd0);
        step();
        idle();
        step();
        step();
        check("r0_fwd_cnt", 32'(fwd_cnt), 32'd4);
        check("r0_stall_cnt", 32'(stall_cnt), 32'd1);

        // ---- Flush beats Stall: lw $8 ; dependent in ID with Flush ----
        lw8();
        step();
        add9_8_1();
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        step();
        flush = 1'b0;
        idle();
        // A wrongly admitted add would see the lw tag in MEM here.
        check("flush_bubble_fa", 32'(fwd_a), 32'd0);
        check("flush_stall_cnt", 32'(stall_cnt), 32'd1);
        step();
        check("flush_bubble_wb_fa", 32'(fwd_a), 32'd0);
        step();
        step();

        // ---- reset mid-stall ----
        lw8();
        step();
        add9_8_1();
        check("rms_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rms_stall_after", 32'(stall), 32'd0);
        check("rms_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rms_fwd_cnt", 32'(fwd_cnt), 32'd0);
        step();
        idle();
        check("rms_load_discarded_fa", 32'(fwd_a), 32'd0);
        step();
        step();
        step();

        // ---- saturation: 20 load-use pairs ----
        for (int i = 0; i < 20; i++) begin
            lw8();
            step();
            add9_8_1();
            step();
            step();
        end
        idle();
        step();
        step();
        check("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
        check("sat_fwd_cnt4", 32'(fwd_cnt4), 32'd15);
        check("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
        check("sat_fwd_cnt16", 32'(fwd_cnt), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
